// File: rtl/arbiter_pkg.sv
// Shared types, default sizes and helpers for the weighted round-robin arbiter.
// Optional feature macro: ARB_LOCK_EN (burst-lock per requester).
package arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int ARB_N    = 4;
  localparam int ARB_WW   = 4;

  // Widest weight field eff_weight() can handle; WW must not exceed it.
  localparam int ARB_WMAX = 16;

  // A weight of zero still grants one beat, so the holder always makes progress.
  function automatic logic [ARB_WMAX-1:0] eff_weight(input logic [ARB_WMAX-1:0] w);
    return (w == '0) ? {{(ARB_WMAX-1){1'b0}}, 1'b1} : w;
  endfunction

endpackage

// File: rtl/arbiter_wrr_rr_pick.sv
// Combinational rotate-priority finder: returns the first set bit of req
// searching upward from start and wrapping from N-1 back to 0.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [IW:0]   sum;
  logic [IW-1:0] cand;

  // Walk the N positions in rotated order and latch the first requester seen.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    sum   = '0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, start} + (IW+1)'(i);
      if (sum >= (IW+1)'(N)) begin
        sum = sum - (IW+1)'(N);
      end
      cand = sum[IW-1:0];
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/arbiter_wrr.sv
// Weighted round-robin arbiter with burst holding. A holder keeps the grant
// for up to its weight in beats, then the grant rotates without a gap.
// Optional feature macro: ARB_LOCK_EN lets a holder assert lock to extend
// its burst past the weight budget for as long as it keeps requesting.
module arbiter_wrr
  import arbiter_pkg::*;
#(
  parameter int N  = ARB_N,
  parameter int WW = ARB_WW,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]    req,
  input  logic [N*WW-1:0] weight,
  input  logic [N-1:0]    lock,
  output logic [N-1:0]    grant,
  output logic [IW-1:0]   grant_id,
  output logic            busy
);

  arb_state_t    state;
  logic [IW-1:0] ptr;
  logic [WW-1:0] beat_cnt;
  logic [WW-1:0] wlimit;

  logic          holder_req;
  logic [IW-1:0] next_after;
  logic [IW-1:0] pick_start;
  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic [WW-1:0] win_weight;
  logic [WW-1:0] win_limit;
  logic [N-1:0]  win_onehot;
  logic          budget_hit;
  logic          hold_lock;
  logic          release_now;

  // The holder is whoever grant_id names; its successor wraps at N-1.
  assign holder_req = req[grant_id];
  assign next_after = (grant_id == IW'(N-1)) ? '0 : grant_id + 1'b1;

  // One finder serves both idle arbitration (from ptr) and release
  // arbitration (from the slot after the holder, so the holder is last).
  assign pick_start = (state == GRANT) ? next_after : ptr;

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req   (req),
    .start (pick_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Budget of the candidate winner, captured only when its grant is issued.
  assign win_weight = weight[pick_idx*WW +: WW];
  assign win_limit  = WW'(eff_weight(ARB_WMAX'(win_weight)));
  assign win_onehot = {{(N-1){1'b0}}, 1'b1} << pick_idx;

  // This cycle is the last budgeted beat when the count reaches wlimit-1.
  assign budget_hit = (beat_cnt == (wlimit - 1'b1));

`ifdef ARB_LOCK_EN
  // A requesting holder with lock set cannot be released by its budget.
  assign hold_lock = lock[grant_id] & holder_req;
`else
  logic unused_lock;
  assign unused_lock = ^lock;
  assign hold_lock   = 1'b0;
`endif

  // Release when the holder drops its request or spends its last beat.
  assign release_now = !holder_req || (budget_hit && !hold_lock);

  // Arbitration FSM with registered grant, grant_id, busy and burst counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      beat_cnt <= '0;
      wlimit   <= '0;
      grant    <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            state    <= GRANT;
            grant    <= win_onehot;
            grant_id <= pick_idx;
            busy     <= 1'b1;
            beat_cnt <= '0;
            wlimit   <= win_limit;
          end
        end
        GRANT: begin
          if (release_now) begin
            ptr <= next_after;
            if (pick_found) begin
              grant    <= win_onehot;
              grant_id <= pick_idx;
              busy     <= 1'b1;
              beat_cnt <= '0;
              wlimit   <= win_limit;
            end else begin
              state    <= IDLE;
              grant    <= '0;
              grant_id <= '0;
              busy     <= 1'b0;
              beat_cnt <= '0;
            end
          end else if (!budget_hit) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          grant    <= '0;
          grant_id <= '0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arbiter_wrr.sv
// Self-checking bench for arbiter_wrr (N=4, WW=4). Vectors are tables of
// {req, weight, lock, expected grant}; expectations are queued when driven
// and popped once the DUT's registered output is visible.
module tb_arbiter_wrr;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] weight;
  logic [3:0]  lock;
  logic [3:0]  grant;
  logic [1:0]  grant_id;
  logic        busy;

  typedef struct {
    logic [3:0]  req;
    logic [15:0] weight;
    logic [3:0]  lock;
    logic [3:0]  exp_grant;
  } vec_t;

  vec_t       vecs[$];
  logic [3:0] sb[$];
  int         asserts;
  int         failures;

  arbiter_wrr #(.N(4), .WW(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .weight   (weight),
    .lock     (lock),
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int onehotIdx(input logic [3:0] g);
    for (int i = 0; i < 4; i++) begin
      if (g[i]) return i;
    end
    return 0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    asserts++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void addVec(input logic [3:0] r, input logic [15:0] w,
                                 input logic [3:0] l, input logic [3:0] g);
    vec_t v;
    v.req       = r;
    v.weight    = w;
    v.lock      = l;
    v.exp_grant = g;
    vecs.push_back(v);
  endfunction

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    req    = v.req;
    weight = v.weight;
    lock   = v.lock;
    sb.push_back(v.exp_grant);
  endtask

  task automatic checkOutput(input string name);
    logic [3:0] e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({name, " scoreboard"}, 0, 1);
    end else begin
      e = sb.pop_front();
      check({name, " grant"}, int'(grant), int'(e));
      check({name, " busy"}, int'(busy), int'(|e));
      check({name, " grant_id"}, int'(grant_id), onehotIdx(e));
    end
  endtask

  task automatic runTable(input string name);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("%s[%0d]", name, i));
    end
    vecs.delete();
  endtask

  task automatic doReset(input string name);
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    lock  = '0;
    #1;
    check({name, " rst grant"}, int'(grant), 0);
    check({name, " rst busy"}, int'(busy), 0);
    check({name, " rst grant_id"}, int'(grant_id), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    asserts  = 0;
    failures = 0;
    rst_n    = 1'b0;
    req      = '0;
    weight   = '0;
    lock     = '0;

    // Equal weights of 1: single-cycle rotation.
    doReset("eq1");
    addVec(4'hF, 16'h1111, 4'h0, 4'b0001);
    addVec(4'hF, 16'h1111, 4'h0, 4'b0010);
    addVec(4'hF, 16'h1111, 4'h0, 4'b0100);
    addVec(4'hF, 16'h1111, 4'h0, 4'b1000);
    addVec(4'hF, 16'h1111, 4'h0, 4'b0001);
    addVec(4'hF, 16'h1111, 4'h0, 4'b0010);
    runTable("eq1");

    // Weights {4,3,2,1}: burst lengths 1,2,3,4 with no gaps.
    doReset("w4321");
    addVec(4'hF, 16'h4321, 4'h0, 4'b0001);
    for (int i = 0; i < 2; i++) addVec(4'hF, 16'h4321, 4'h0, 4'b0010);
    for (int i = 0; i < 3; i++) addVec(4'hF, 16'h4321, 4'h0, 4'b0100);
    for (int i = 0; i < 4; i++) addVec(4'hF, 16'h4321, 4'h0, 4'b1000);
    addVec(4'hF, 16'h4321, 4'h0, 4'b0001);
    addVec(4'hF, 16'h4321, 4'h0, 4'b0010);
    runTable("w4321");

    // Weights 3, two sparse requesters alternate.
    doReset("w3");
    for (int i = 0; i < 3; i++) addVec(4'h5, 16'h3333, 4'h0, 4'b0001);
    for (int i = 0; i < 3; i++) addVec(4'h5, 16'h3333, 4'h0, 4'b0100);
    for (int i = 0; i < 3; i++) addVec(4'h5, 16'h3333, 4'h0, 4'b0001);
    runTable("w3");

    // Lone requester re-granted continuously, then released to idle.
    doReset("single");
    for (int i = 0; i < 5; i++) addVec(4'h2, 16'h0020, 4'h0, 4'b0010);
    addVec(4'h0, 16'h0020, 4'h0, 4'b0000);
    addVec(4'h0, 16'h0020, 4'h0, 4'b0000);
    runTable("single");

    // Holder drops early; next winner comes from the slot after it.
    doReset("drop");
    for (int i = 0; i < 3; i++) addVec(4'h5, 16'h4444, 4'h0, 4'b0001);
    addVec(4'h4, 16'h4444, 4'h0, 4'b0100);
    addVec(4'h4, 16'h4444, 4'h0, 4'b0100);
    runTable("drop");
    doReset("drop2");
    addVec(4'h1, 16'h4444, 4'h0, 4'b0001);
    addVec(4'h1, 16'h4444, 4'h0, 4'b0001);
    addVec(4'h6, 16'h4444, 4'h0, 4'b0010);
    addVec(4'h6, 16'h4444, 4'h0, 4'b0010);
    runTable("drop2");

    // Weight changes mid-burst do not shorten the current burst.
    doReset("wchg");
    addVec(4'h3, 16'h0013, 4'h0, 4'b0001);
    addVec(4'h3, 16'h0011, 4'h0, 4'b0001);
    addVec(4'h3, 16'h0011, 4'h0, 4'b0001);
    addVec(4'h3, 16'h0011, 4'h0, 4'b0010);
    addVec(4'h3, 16'h0011, 4'h0, 4'b0001);
    addVec(4'h3, 16'h0011, 4'h0, 4'b0010);
    runTable("wchg");

    // Zero weights behave as one.
    doReset("w0");
    addVec(4'h3, 16'h0000, 4'h0, 4'b0001);
    addVec(4'h3, 16'h0000, 4'h0, 4'b0010);
    addVec(4'h3, 16'h0000, 4'h0, 4'b0001);
    runTable("w0");

    // Maximum weight 15 gives a 15-beat burst.
    doReset("wmax");
    for (int i = 0; i < 15; i++) addVec(4'h3, 16'h000F, 4'h0, 4'b0001);
    addVec(4'h3, 16'h000F, 4'h0, 4'b0010);
    runTable("wmax");

    // Lock extends a burst when enabled, ignored otherwise.
    doReset("lock");
`ifdef ARB_LOCK_EN
    for (int i = 0; i < 6; i++) addVec(4'h3, 16'h0000, 4'h1, 4'b0001);
    addVec(4'h3, 16'h0000, 4'h0, 4'b0010);
`else
    addVec(4'h3, 16'h0000, 4'h1, 4'b0001);
    addVec(4'h3, 16'h0000, 4'h1, 4'b0010);
    addVec(4'h3, 16'h0000, 4'h1, 4'b0001);
    addVec(4'h3, 16'h0000, 4'h1, 4'b0010);
`endif
    runTable("lock");

    // Reset mid-burst: async drop, and ptr restarts at 0 afterwards.
    doReset("midrst");
    addVec(4'h4, 16'h4444, 4'h0, 4'b0100);
    addVec(4'h0, 16'h4444, 4'h0, 4'b0000);
    addVec(4'h1, 16'h4444, 4'h0, 4'b0001);
    addVec(4'h1, 16'h4444, 4'h0, 4'b0001);
    runTable("midrst");
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst async grant", int'(grant), 0);
    check("midrst async busy", int'(busy), 0);
    check("midrst async grant_id", int'(grant_id), 0);
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    addVec(4'hA, 16'h4444, 4'h0, 4'b0010);
    runTable("postrst");
    doReset("rst8");
    addVec(4'h8, 16'h4444, 4'h0, 4'b1000);
    addVec(4'h8, 16'h4444, 4'h0, 4'b1000);
    runTable("rst8");

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
